// File: rtl/burst_line_adapter_pkg.sv
// burst_line_adapter_pkg
//   Shared types and helpers for the line-to-burst adapter.
//   - state_t     : adapter FSM state encoding
//   - beat_stride : byte distance between consecutive beats of a burst
package burst_line_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_REQ     = 3'd1,
    RD_COLLECT = 3'd2,
    WR_BEAT    = 3'd3,
    DONE       = 3'd4
  } state_t;

  function automatic int unsigned beat_stride(input int unsigned beat_w);
    return beat_w / 8;
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter
//   Beat index counter shared by the read and write paths. The counter is
//   log2(BEATS) bits wide, so the last beat is the all-ones value. Clear has
//   priority over enable; the adapter clears it on the final beat so the
//   return to 0 is always explicit.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0
//   en       : advance count by one
//   cnt      : current beat index
//   last     : cnt is the final beat index
module burst_beat_counter
  import burst_line_adapter_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/burst_line_adapter.sv
// burst_line_adapter
//   Converts one LINE_W-bit cache line read or write on the DFP side into
//   BEATS = LINE_W/BEAT_W beat transfers on the bmem side. Reads issue one
//   burst request, collect beats into a line buffer and complete with a
//   single-cycle dfp_resp; writes stream latched line slices under bmem_ready
//   backpressure.
// Build option:
//   BURST_LINE_ADAPTER_RADDR_CHECK_EN - check bmem_raddr of each returning
//   beat against the expected beat address; mismatching beats are dropped
//   and stray or mismatching beats set the sticky err flag. Without it
//   bmem_raddr is unused and err is constant 0.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   dfp_addr/read/write/wdata         : line request from the cache
//   dfp_rdata, dfp_resp               : read line, completion pulse
//   bmem_addr/read/write/wdata/ready  : burst request / write beat handshake
//   bmem_raddr/rdata/rvalid           : returning read beats
//   busy                              : FSM not idle
//   err                               : sticky protocol error
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for dfp_read / dfp_write (read wins)
// RD_REQ     | bmem_read held at base until bmem_ready
// RD_COLLECT | accepting read beats into the line buffer
// WR_BEAT    | presenting write slice cnt until bmem_ready
// DONE       | one-cycle dfp_resp, requests ignored
module burst_line_adapter
  import burst_line_adapter_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned BEATS  = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned STRIDE = beat_stride(BEAT_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  if (LINE_W % BEAT_W != 0) begin : g_chk_div
    $error("burst_line_adapter: LINE_W must be a multiple of BEAT_W");
  end
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_chk_pow2
    $error("burst_line_adapter: LINE_W/BEAT_W must be a power of two >= 2");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] rbuf;
  logic [LINE_W-1:0] line_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              cnt_en;
  logic              cnt_clr;
  logic              raddr_ok;
  logic              beat_ok;

`ifdef BURST_LINE_ADAPTER_RADDR_CHECK_EN
  assign raddr_ok = (bmem_raddr == base + ADDR_W'(cnt) * ADDR_W'(STRIDE));
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign raddr_ok     = 1'b1;
`endif

  // Beats are only meaningful while collecting; anything else is dropped.
  assign beat_ok = (state == RD_COLLECT) && bmem_rvalid && raddr_ok;

  assign cnt_en  = beat_ok || ((state == WR_BEAT) && bmem_ready);
  // Held at 0 outside the beat states so each burst starts at slice 0.
  assign cnt_clr = ((state != RD_COLLECT) && (state != WR_BEAT)) || (cnt_en && cnt_last);

  burst_beat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .last(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dfp_read) begin
          state_nxt = RD_REQ;
        end else if (dfp_write) begin
          state_nxt = WR_BEAT;
        end
      end
      RD_REQ:     if (bmem_ready) state_nxt = RD_COLLECT;
      RD_COLLECT: if (beat_ok && cnt_last) state_nxt = DONE;
      WR_BEAT:    if (bmem_ready && cnt_last) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = base;
      end
      WR_BEAT: begin
        bmem_write = 1'b1;
        bmem_addr  = base;
        bmem_wdata = wbuf[cnt*BEAT_W +: BEAT_W];
      end
      DONE:    dfp_resp = 1'b1;
      default: ;
    endcase
  end

  // Line buffer with the current beat merged in; on the last beat this is
  // the complete line, published to dfp_rdata in the same edge.
  always_comb begin
    line_nxt = rbuf;
    line_nxt[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      dfp_rdata <= '0;
    end else begin
      if ((state == IDLE) && (dfp_read || dfp_write)) begin
        base <= dfp_addr & ~OFF_MASK;
      end
      if ((state == IDLE) && !dfp_read && dfp_write) begin
        wbuf <= dfp_wdata;
      end
      if (beat_ok) begin
        rbuf <= line_nxt;
        if (cnt_last) begin
          dfp_rdata <= line_nxt;
        end
      end
    end
  end

`ifdef BURST_LINE_ADAPTER_RADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bmem_rvalid && ((state != RD_COLLECT) || !raddr_ok)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_line_adapter.sv
`timescale 1ns/1ps
module tb_burst_line_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel;          // 0: 256/64 instance, 1: 512/64 instance
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [511:0] dfp_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  logic [255:0] a_rdata;  logic a_resp;  logic [31:0] a_addr;
  logic a_read, a_write;  logic [63:0] a_wdata;  logic a_busy, a_err;
  logic [511:0] b_rdata;  logic b_resp;  logic [31:0] b_addr;
  logic b_read, b_write;  logic [63:0] b_wdata;  logic b_busy, b_err;

  burst_line_adapter #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) u_dut4 (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read & ~sel), .dfp_write(dfp_write & ~sel),
    .dfp_wdata(dfp_wdata[255:0]), .dfp_rdata(a_rdata), .dfp_resp(a_resp),
    .bmem_addr(a_addr), .bmem_read(a_read), .bmem_write(a_write), .bmem_wdata(a_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid & ~sel), .busy(a_busy), .err(a_err));

  burst_line_adapter #(.LINE_W(512), .BEAT_W(64), .ADDR_W(32)) u_dut8 (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read & sel), .dfp_write(dfp_write & sel),
    .dfp_wdata(dfp_wdata), .dfp_rdata(b_rdata), .dfp_resp(b_resp),
    .bmem_addr(b_addr), .bmem_read(b_read), .bmem_write(b_write), .bmem_wdata(b_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid & sel), .busy(b_busy), .err(b_err));

  logic [511:0] o_rdata;
  logic [31:0]  o_addr;
  logic [63:0]  o_wdata;
  logic         o_resp, o_read, o_write, o_busy, o_err;
  assign o_rdata = sel ? b_rdata : {256'd0, a_rdata};
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_resp  = sel ? b_resp  : a_resp;
  assign o_read  = sel ? b_read  : a_read;
  assign o_write = sel ? b_write : a_write;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_err   = sel ? b_err   : a_err;

  // Reference state: last completed line and expected err, per instance.
  logic [511:0] last_line [2];
  logic [1:0]   exp_err;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int beats_of();
    return sel ? 8 : 4;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    int unsigned lb;
    lb = sel ? 64 : 32;
    return addr / lb * lb;
  endfunction

  // A beat seen outside collection is an error only with address checking.
  task automatic stray();
`ifdef BURST_LINE_ADAPTER_RADDR_CHECK_EN
    exp_err[sel] = 1'b1;
`endif
  endtask

  task automatic do_read(input logic [31:0] addr, input bit directed, input bit with_write,
                         input int bad_at, input int rst_after);
    logic [63:0]  beat [8];
    logic [511:0] exp_line;
    logic [31:0]  base;
    int n, k, cyc;
    bit v, acc, early, wr_seen, dropped;
    n = beats_of();
    base = line_base(addr);
    exp_line = '0;
    for (int i = 0; i < n; i++) begin
      beat[i] = directed ? 64'(32'hA + i) : {$urandom, $urandom};
      exp_line[i*64 +: 64] = beat[i];
    end
    dfp_addr  = addr;
    dfp_read  = 1'b1;
    dfp_write = with_write;
    for (int i = 0; i < 16; i++) dfp_wdata[i*32 +: 32] = $urandom;
    @(negedge clk);
    cyc = 0; early = 0; wr_seen = 0; dropped = 0;
    do begin
      check("rd_req_read", o_read, 1'b1);
      check("rd_req_addr", o_addr, base);
      wr_seen |= o_write;
      acc = directed || ($urandom % 3 != 0);
      bmem_ready = acc;
      if (acc && !directed && ($urandom % 2 == 1)) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = {$urandom, $urandom};
        bmem_raddr  = base;
        stray();
      end
      @(negedge clk);
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      cyc++;
    end while (!acc && cyc < 20);
    check("rd_req_handshake", acc, 1'b1);
    check("rd_read_dropped", o_read, 1'b0);
    k = 0; cyc = 0;
    while (k < n && cyc < 100) begin
      if (rst_after >= 0 && k == rst_after) break;
      v = directed || ($urandom % 3 != 0);
      bmem_rvalid = v;
      bmem_rdata  = v ? beat[k] : {$urandom, $urandom};
      bmem_raddr  = base + k * 8;
`ifdef BURST_LINE_ADAPTER_RADDR_CHECK_EN
      if (v && k == bad_at && !dropped) begin
        bmem_raddr = base + k * 8 + 8;
        bmem_rdata = ~beat[k];
        dropped    = 1'b1;
        exp_err[sel] = 1'b1;
        v = 1'b0;
      end
`endif
      wr_seen |= o_write;
      @(negedge clk);
      bmem_rvalid = 1'b0;
      if (v) k++;
      if (k < n) early |= o_resp;
      cyc++;
    end
    if (rst_after >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      dfp_read = 1'b0;
      dfp_write = 1'b0;
      exp_err = '0;
      last_line[0] = '0;
      last_line[1] = '0;
      check("rst_resp", o_resp, 1'b0);
      check("rst_read", o_read, 1'b0);
      check("rst_write", o_write, 1'b0);
      check("rst_addr", o_addr, 32'd0);
      check("rst_wdata", o_wdata, 64'd0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_rdata", o_rdata, 512'd0);
      check("rst_err", o_err, 1'b0);
      for (int i = k; i < n; i++) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = beat[i];
        bmem_raddr  = base + i * 8;
        stray();
        @(negedge clk);
      end
      bmem_rvalid = 1'b0;
      @(negedge clk);
      check("late_busy", o_busy, 1'b0);
      check("late_rdata", o_rdata, last_line[sel]);
      check("late_err", o_err, exp_err[sel]);
      return;
    end
    check("rd_beats", k, n);
    check("rd_resp", o_resp, 1'b1);
    check("rd_line", o_rdata, exp_line);
    check("rd_early_resp", early, 1'b0);
    check("rd_no_write", wr_seen, 1'b0);
    check("rd_err", o_err, exp_err[sel]);
    last_line[sel] = exp_line;
    dfp_read = 1'b0;
    dfp_write = 1'b0;
    @(negedge clk);
    check("rd_resp_pulse", o_resp, 1'b0);
    check("rd_idle", o_busy, 1'b0);
    check("rd_hold", o_rdata, last_line[sel]);
  endtask

  task automatic do_write(input logic [31:0] addr, input bit toggle);
    logic [511:0] wd;
    logic [31:0]  base;
    int n, k, cyc;
    bit acc, ph, early, rd_seen;
    n = beats_of();
    base = line_base(addr);
    for (int i = 0; i < 16; i++) wd[i*32 +: 32] = $urandom;
    dfp_addr  = addr;
    dfp_write = 1'b1;
    dfp_read  = 1'b0;
    dfp_wdata = wd;
    @(negedge clk);
    k = 0; cyc = 0; ph = 1'b1; early = 0; rd_seen = 0;
    while (k < n && cyc < 100) begin
      check("wr_valid", o_write, 1'b1);
      check("wr_addr", o_addr, base);
      check("wr_data", o_wdata, wd[k*64 +: 64]);
      rd_seen |= o_read;
      acc = toggle ? ph : 1'($urandom % 2);
      ph = ~ph;
      bmem_ready = acc;
      @(negedge clk);
      bmem_ready = 1'b0;
      if (acc) k++;
      if (k < n) early |= o_resp;
      cyc++;
    end
    check("wr_beats", k, n);
    check("wr_resp", o_resp, 1'b1);
    check("wr_early_resp", early, 1'b0);
    check("wr_no_read", rd_seen, 1'b0);
    check("wr_no_extra_beat", o_write, 1'b0);
    dfp_write = 1'b0;
    @(negedge clk);
    check("wr_resp_pulse", o_resp, 1'b0);
    check("wr_idle", o_busy, 1'b0);
    check("wr_rdata_hold", o_rdata, last_line[sel]);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sel = 1'b0;
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    exp_err = '0;
    last_line[0] = '0;
    last_line[1] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_busy", o_busy, 1'b0);
      check("reset_outputs", {o_resp, o_read, o_write, o_err}, 4'b0);
      check("reset_addr", o_addr, 32'd0);
      check("reset_rdata", o_rdata, 512'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_read(32'h1234_5678, 1'b1, 1'b0, -1, -1);
    check("directed_line", o_rdata[255:0], {64'hD, 64'hC, 64'hB, 64'hA});
    do_write(32'h0000_1040, 1'b1);
    do_write(32'h0000_2000, 1'b0);
    do_read(32'h0BAD_F00D, 1'b0, 1'b1, -1, -1);
    do_read(32'h0000_3000, 1'b0, 1'b0, -1, 2);
    do_read(32'h0000_4020, 1'b0, 1'b0, -1, -1);

    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      bmem_raddr  = $urandom;
      stray();
      @(negedge clk);
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_idle", o_busy, 1'b0);
    check("stray_rdata", o_rdata, last_line[sel]);
    check("stray_err", o_err, exp_err[sel]);

    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom % 2);
      if ($urandom % 2 == 1) do_read($urandom, 1'b0, 1'($urandom % 2), -1, -1);
      else                   do_write($urandom, 1'b0);
    end

    sel = 1'b1;
    do_read(32'h8000_0078, 1'b1, 1'b0, -1, -1);
    do_write(32'h8000_0100, 1'b1);
    do_read(32'h8000_0200, 1'b0, 1'b0, -1, -1);

`ifdef BURST_LINE_ADAPTER_RADDR_CHECK_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = '0;
    last_line[0] = '0;
    last_line[1] = '0;
    sel = 1'b0;
    check("chk_err_clear", o_err, 1'b0);
    do_read(32'h0000_5000, 1'b1, 1'b0, 1, -1);
    check("chk_err_set", o_err, 1'b1);
    do_read(32'h0000_6000, 1'b1, 1'b0, -1, -1);
    check("chk_err_sticky", o_err, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
